// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable sequencer.
// State and mode constants used by the controller and bench.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_HALT          = 2'd0,
        ST_RUN           = 2'd1,
        ST_STEP_ARM      = 2'd2,
        ST_HALTED_BY_CPU = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

endpackage

// File: rtl/clk_tick_gen.sv
// Divider that emits one tick every max+1 cycles while enabled.
// A restart clears the count and suppresses the tick that cycle.
module clk_tick_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] max,
    input  logic             restart,
    output logic             tick
);

    logic [CNT_W-1:0] count;
    logic             at_max;

    assign at_max = (count >= max);
    assign tick   = en && !restart && at_max;

    // Count 0..max and wrap; held at 0 when idle or restarting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || restart || at_max) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: run/step/halt modes on one board clock.
// Issues single-cycle cpu_ce pulses and counts them for the display.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter logic [31:0] RATE0 = 32'd0,
    parameter logic [31:0] RATE1 = 32'd49,
    parameter logic [31:0] RATE2 = 32'd4_999_999,
    parameter logic [31:0] RATE3 = 32'd49_999_999,
    parameter int          CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [1:0]       rate_sel,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    state_t           st;
    logic [1:0]       rate_q;
    logic             step_q;
    logic             tick;
    logic             restart;
    logic             step_edge;
    logic [CNT_W-1:0] max;

    assign state     = st;
    assign restart   = (rate_sel != rate_q);
    assign step_edge = step_req && !step_q;

    // Divisor select for the run rate.
    always_comb begin
        max = CNT_W'(RATE0);
        unique case (rate_sel)
            2'd0: max = CNT_W'(RATE0);
            2'd1: max = CNT_W'(RATE1);
            2'd2: max = CNT_W'(RATE2);
            2'd3: max = CNT_W'(RATE3);
        endcase
    end

    clk_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (st == ST_RUN),
        .max     (max),
        .restart (restart),
        .tick    (tick)
    );

    // Mode FSM with registered enable pulse; current state picks the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_HALT;
            cpu_ce <= 1'b0;
            step_q <= 1'b0;
            rate_q <= 2'd0;
        end else begin
            step_q <= step_req;
            rate_q <= rate_sel;
            cpu_ce <= 1'b0;
            unique case (st)
                ST_HALT: begin
                    if (mode == MODE_RUN && !halt_req) begin
                        st <= ST_RUN;
                    end else if (mode == MODE_STEP) begin
                        st <= ST_STEP_ARM;
                    end
                end
                ST_RUN: begin
                    cpu_ce <= tick && !halt_req;
                    if (mode != MODE_RUN) begin
                        st <= ST_HALT;
                    end else if (halt_req) begin
                        st <= ST_HALTED_BY_CPU;
                    end
                end
                ST_STEP_ARM: begin
                    cpu_ce <= step_edge;
                    if (mode != MODE_STEP) begin
                        st <= ST_HALT;
                    end
                end
                ST_HALTED_BY_CPU: begin
                    if (mode == MODE_HALT) begin
                        st <= ST_HALT;
                    end
                end
                default: st <= ST_HALT;
            endcase
        end
    end

    // Retired-pulse counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (cnt_clr) begin
            cycle_count <= '0;
        end else if (cpu_ce) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

endmodule
